// File: rtl/atan2_cordic.sv
// atan2_cordic: iterative CORDIC vectoring unit, o_th = atan2(i_y, i_x) in float32 radians
//   i_clk    clock, rising edge
//   i_rst_n  synchronous active-low reset
//   i_valid  request strobe, taken only while o_ready=1
//   i_x/i_y  float32 operands (cos-like / sin-like)
//   o_ready  high while idle
//   o_th     float32 angle in [-pi, +pi], held until the next result
//   o_valid  one-cycle pulse marking a new o_th
module atan2_cordic #(
  parameter int ITER = 24
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [31:0] i_x,
  input  logic [31:0] i_y,
  output logic        o_ready,
  output logic [31:0] o_th,
  output logic        o_valid
);
  typedef enum logic [1:0] {IDLE, ALIGN, ROT, NORM} state_t;
  localparam logic signed [31:0] HALF_PI = 32'sd843314857;
  state_t r_state, w_next;
  logic [31:0] r_xin, r_yin, r_th;
  logic signed [33:0] r_x, r_y;
  logic signed [31:0] r_z;
  logic [4:0] r_cnt;
  logic r_valid;
  logic [7:0] w_xe, w_ye, w_d;
  logic [23:0] w_xm, w_ym;
  logic w_big_x, w_xneg, w_yneg, w_nan, w_zero;
  logic [33:0] w_xa, w_ya;
  logic signed [33:0] w_xs, w_ys, w_xsh, w_ysh;
  logic signed [31:0] w_atan;
  logic [31:0] w_zmag, w_th;
  logic [5:0] w_lz;
  logic [22:0] w_mant;
  // round(atan(2^-i) * 2^29)
  function automatic logic signed [31:0] atan_rom(input logic [4:0] i);
    case (i)
      5'd0:  atan_rom = 32'sd421657428;
      5'd1:  atan_rom = 32'sd248918915;
      5'd2:  atan_rom = 32'sd131521918;
      5'd3:  atan_rom = 32'sd66762579;
      5'd4:  atan_rom = 32'sd33510843;
      5'd5:  atan_rom = 32'sd16771758;
      5'd6:  atan_rom = 32'sd8387925;
      5'd7:  atan_rom = 32'sd4194219;
      5'd8:  atan_rom = 32'sd2097141;
      5'd9:  atan_rom = 32'sd1048575;
      5'd10: atan_rom = 32'sd524288;
      default: atan_rom = (i < 5'd30) ? (32'sd1 <<< (29 - i)) : 32'sd0;
    endcase
  endfunction
  assign w_xe = r_xin[30:23];
  assign w_ye = r_yin[30:23];
  assign w_nan = (w_xe == 8'hff) || (w_ye == 8'hff);
  assign w_zero = (w_xe == 8'h00) && (w_ye == 8'h00);
  assign w_xm = (w_xe == 8'h00) ? 24'd0 : {1'b1, r_xin[22:0]};
  assign w_ym = (w_ye == 8'h00) ? 24'd0 : {1'b1, r_yin[22:0]};
  assign w_big_x = w_xe >= w_ye;
  assign w_d = w_big_x ? w_xe - w_ye : w_ye - w_xe;
  // leading one of the larger operand lands on bit 30; shifts past 33 fall to zero
  assign w_xa = {3'b000, w_xm, 7'b0} >> (w_big_x ? 8'd0 : w_d);
  assign w_ya = {3'b000, w_ym, 7'b0} >> (w_big_x ? w_d : 8'd0);
  assign w_xs = r_xin[31] ? -w_xa : w_xa;
  assign w_ys = r_yin[31] ? -w_ya : w_ya;
  assign w_xneg = w_xs[33];
  assign w_yneg = w_ys[33];
  assign w_xsh = r_x >>> r_cnt;
  assign w_ysh = r_y >>> r_cnt;
  assign w_atan = atan_rom(r_cnt);
  assign w_zmag = r_z[31] ? 32'(-r_z) : 32'(r_z);
  always_comb begin
    w_lz = 6'd32;
    for (int k = 0; k < 32; k++) w_lz = w_zmag[k] ? 6'(31 - k) : w_lz;
  end
  assign w_mant = 23'((w_zmag << w_lz) >> 8);
  // value = mag * 2^-29 with leading one at bit (31-lz): biased exponent 129-lz
  assign w_th = w_nan ? 32'h7fc00000 :
                (w_zero || w_zmag == 32'd0) ? 32'h0 : {r_z[31], 8'(129 - w_lz), w_mant};
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  w_next = i_valid ? ALIGN : IDLE;
      ALIGN: w_next = ROT;
      ROT:   w_next = (r_cnt == 5'(ITER - 1)) ? NORM : ROT;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_valid <= 1'b0;
      r_th <= '0;
      r_xin <= '0;
      r_yin <= '0;
      r_x <= '0;
      r_y <= '0;
      r_z <= '0;
    end else begin
      r_state <= w_next;
      r_valid <= (r_state == NORM);
      if (r_state == IDLE && i_valid) begin
        r_xin <= i_x;
        r_yin <= i_y;
      end
      if (r_state == ALIGN) begin
        r_cnt <= '0;
        r_x <= w_xneg ? (w_yneg ? -w_ys : w_ys) : w_xs;
        r_y <= w_xneg ? (w_yneg ? w_xs : -w_xs) : w_ys;
        r_z <= w_xneg ? (w_yneg ? -HALF_PI : HALF_PI) : 32'sd0;
      end
      if (r_state == ROT) begin
        r_cnt <= r_cnt + 5'd1;
        r_x <= r_y[33] ? r_x - w_ysh : r_x + w_ysh;
        r_y <= r_y[33] ? r_y + w_xsh : r_y - w_xsh;
        r_z <= r_y[33] ? r_z - w_atan : r_z + w_atan;
      end
      if (r_state == NORM) begin
        r_cnt <= '0;
        r_th <= w_th;
      end
    end
  end
  assign o_ready = (r_state == IDLE);
  assign o_th = r_th;
  assign o_valid = r_valid;
endmodule

// File: tb/tb_atan2_cordic.sv
// tb_atan2_cordic: scoreboard bench for atan2_cordic
module tb_atan2_cordic;
  localparam int ITER = 24;
  localparam int LAT = ITER + 3;
  localparam real TOL = 1.0 / 1048576.0;
  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
  } req_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_valid = 1'b0;
  logic [31:0] i_x = '0, i_y = '0;
  logic o_ready, o_valid;
  logic [31:0] o_th;
  req_t sb[$];
  int checks = 0, failures = 0;
  atan2_cordic #(.ITER(ITER)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_x(i_x), .i_y(i_y),
    .o_ready(o_ready), .o_th(o_th), .o_valid(o_valid)
  );
  always #5 clk = ~clk;
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'h00) return 0.0;
    d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction
  function automatic logic is_exact(input req_t r, output logic [31:0] v);
    v = 32'h0;
    if (r.x[30:23] == 8'hff || r.y[30:23] == 8'hff) begin
      v = 32'h7fc00000;
      return 1'b1;
    end
    return (r.x[30:23] == 8'h00) && (r.y[30:23] == 8'h00);
  endfunction
  function automatic real ref_th(input req_t r);
    return $atan2(f2r(r.y), f2r(r.x));
  endfunction
  function automatic logic [31:0] rnd_f();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(118, 136)), 23'($urandom)};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    i_valid = 1'b1;
    i_x = 32'h3f800000;
    i_y = 32'h3f800000;
    repeat (3) step();
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_th !== 32'h0) begin
      failures++;
      $display("FAIL reset_state: ready=%b valid=%b th=%h required 1 0 00000000", o_ready, o_valid, o_th);
    end
    i_valid = 1'b0;
    rst_n = 1'b1;
    step();
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: ready=%b valid=%b required 1 0", o_ready, o_valid);
    end
  endtask
  task automatic test_points();
    logic [31:0] vx[12] = '{32'h3f800000, 32'h00000000, 32'hbf800000, 32'h00000000,
                            32'h3f5db3d7, 32'h3f3504f3, 32'h3f000000, 32'hbf800000,
                            32'h40a00000, 32'h3f800000, 32'h00000000, 32'h7f800000};
    logic [31:0] vy[12] = '{32'h00000000, 32'h3f800000, 32'h00000000, 32'hbf800000,
                            32'h3f000000, 32'h3f3504f3, 32'h3f5db3d7, 32'hbf800000,
                            32'h40a00000, 32'h00000001, 32'h00000000, 32'h3f800000};
    for (int n = 0; n < 12; n++) begin
      req_t r;
      logic [31:0] ev;
      int cnt;
      real err;
      i_x = vx[n];
      i_y = vy[n];
      i_valid = 1'b1;
      sb.push_back('{x: vx[n], y: vy[n]});
      step();
      i_valid = 1'b0;
      cnt = 1;
      while (!o_valid && cnt < 100) begin
        step();
        cnt++;
      end
      checks++;
      if (cnt != LAT) begin
        failures++;
        $display("FAIL latency[%0d]: edges=%0d required %0d", n, cnt, LAT);
      end
      if (o_valid && sb.size() > 0) begin
        r = sb.pop_front();
        checks++;
        if (is_exact(r, ev)) begin
          if (o_th !== ev) begin
            failures++;
            $display("FAIL point[%0d] x=%h y=%h: o_th=%h required %h", n, r.x, r.y, o_th, ev);
          end
        end else begin
          err = f2r(o_th) - ref_th(r);
          if (err < 0.0) err = -err;
          if (!(err <= TOL)) begin
            failures++;
            $display("FAIL point[%0d] x=%h y=%h: o_th=%h (%0.9f) required %0.9f +/- 2^-20",
                     n, r.x, r.y, o_th, f2r(o_th), ref_th(r));
          end
        end
      end
      step();
      checks++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
        failures++;
        $display("FAIL pulse_width[%0d]: valid=%b ready=%b required 0 1", n, o_valid, o_ready);
      end
    end
    sb.delete();
  endtask
  task automatic test_back_to_back();
    int cyc = 0, last = 0, pulses = 0, guard = 0;
    logic [31:0] hold = o_th;
    i_valid = 1'b1;
    while (cyc < 3 * LAT + 2 || (sb.size() > 0 && guard < 200)) begin
      if (cyc >= 3 * LAT + 2) begin
        i_valid = 1'b0;
        guard++;
      end
      i_x = rnd_f();
      i_y = rnd_f();
      if (o_ready && i_valid) sb.push_back('{x: i_x, y: i_y});
      step();
      cyc++;
      if (o_valid) begin
        req_t r;
        real err;
        pulses++;
        if (last != 0) begin
          checks++;
          if (cyc - last != LAT) begin
            failures++;
            $display("FAIL b2b_interval: %0d cycles required %0d", cyc - last, LAT);
          end
        end else begin
          checks++;
          if (cyc != LAT) begin
            failures++;
            $display("FAIL b2b_first: cycle %0d required %0d", cyc, LAT);
          end
        end
        last = cyc;
        hold = o_th;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL b2b_unexpected: o_valid with empty scoreboard, o_th=%h required none", o_th);
        end else begin
          r = sb.pop_front();
          err = f2r(o_th) - ref_th(r);
          if (err < 0.0) err = -err;
          if (!(err <= TOL)) begin
            failures++;
            $display("FAIL b2b_value x=%h y=%h: o_th=%h (%0.9f) required %0.9f +/- 2^-20",
                     r.x, r.y, o_th, f2r(o_th), ref_th(r));
          end
        end
      end else if (last != 0) begin
        checks++;
        if (o_th !== hold) begin
          failures++;
          $display("FAIL b2b_hold: o_th=%h required %h", o_th, hold);
        end
      end
    end
    i_valid = 1'b0;
    checks++;
    if (pulses != 4 || sb.size() != 0) begin
      failures++;
      $display("FAIL b2b_count: pulses=%0d pending=%0d required 4 0", pulses, sb.size());
    end
    sb.delete();
  endtask
  task automatic test_reset_abort();
    int cnt;
    int seen = 0;
    req_t r;
    real err;
    i_x = 32'h3f800000;
    i_y = 32'h3f800000;
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    repeat (9) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (o_valid !== 1'b0 || o_th !== 32'h0) begin
      failures++;
      $display("FAIL abort_reset: valid=%b th=%h required 0 00000000", o_valid, o_th);
    end
    step();
    checks++;
    if (o_ready !== 1'b1 || o_th !== 32'h0 || o_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_release: ready=%b th=%h valid=%b required 1 00000000 0", o_ready, o_th, o_valid);
    end
    repeat (2 * LAT) begin
      step();
      if (o_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL abort_no_valid: pulses=%0d required 0", seen);
    end
    r = '{x: 32'h3f000000, y: 32'h3f5db3d7};
    i_x = r.x;
    i_y = r.y;
    i_valid = 1'b1;
    sb.push_back(r);
    step();
    i_valid = 1'b0;
    cnt = 1;
    while (!o_valid && cnt < 100) begin
      step();
      cnt++;
    end
    checks++;
    if (cnt != LAT) begin
      failures++;
      $display("FAIL abort_recover_latency: edges=%0d required %0d", cnt, LAT);
    end
    r = sb.pop_front();
    err = f2r(o_th) - ref_th(r);
    if (err < 0.0) err = -err;
    checks++;
    if (!(err <= TOL)) begin
      failures++;
      $display("FAIL abort_recover_value: o_th=%h (%0.9f) required %0.9f +/- 2^-20",
               o_th, f2r(o_th), ref_th(r));
    end
  endtask
  initial begin
    test_reset();
    test_points();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
